vga_sync_gen: RTL
=================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL: parameters, one per line.
- H_DISPLAY, default 640: visible pixels per line.
- H_FP, default 16: horizontal front porch.
- H_SYNC, default 96: horizontal sync width.
- H_BP, default 48: horizontal back porch.
- V_DISPLAY, default 480: visible lines.
- V_FP, default 10: vertical front porch.
- V_SYNC, default 2: vertical sync width.
- V_BP, default 33: vertical back porch.
- BLINK_FRAMES, default 32: frames per blink half-period.

REQ-002 SHALL: ports, one per line; one clock; reset asynchronous, active-high.
- clk  in  1  system clock, 50 MHz.
- clr  in  1  asynchronous active-high reset.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- vga_on  out  1  high in the visible region.
- Pixel_X  out  10  current column.
- Pixel_Y  out  9  current row.
- frame_tick  out  1  one-clk pulse at frame start.
- blink  out  1  cursor blink phase (VGA_BLINK_EN only).

Function
REQ-003 SHALL: internal pixel-enable tick toggle every clk; tick=1 on alternate cycles, giving a 25 MHz pixel rate.
REQ-004 SHALL: horizontal counter h_cnt (10 bit) advances only on tick=1; wraps H_TOTAL-1 (799) -> 0.
REQ-005 SHALL: vertical counter v_cnt (10 bit) advances on tick=1 when h_cnt wraps; wraps V_TOTAL-1 (524) -> 0.
REQ-006 SHALL: simultaneous h and v wrap resolves to h_cnt=0, v_cnt=0 in the same tick.
REQ-007 SHALL: all outputs are registered decodes of the counters, updated every clk; one-clk lag behind the counters.
REQ-008 SHALL: vga_on = (h_cnt < H_DISPLAY) and (v_cnt < V_DISPLAY).
REQ-009 SHALL: hsync low exactly for h_cnt in [656, 751]; vsync low exactly for v_cnt in [490, 491].
REQ-010 SHALL: Pixel_X = h_cnt and Pixel_Y = v_cnt[8:0]; Pixel_Y is defined only while vga_on=1 (truncation above 511 is permitted).
REQ-011 SHALL: frame_tick high for exactly one clk following the tick on which both counters wrap to 0.
REQ-012 SHALL: frame period = 2*800*525 = 840000 clk.

Reset
REQ-013 SHALL: clr forces tick=0, h_cnt=0, v_cnt=0 and output values Pixel_X=0, Pixel_Y=0, vga_on=0, hsync=1, vsync=1, frame_tick=0, blink=0 immediately, independent of clk.
REQ-014 SHALL: assertion of clr mid-line or mid-frame abandons the frame; after release the first tick starts a new frame at h_cnt=0, v_cnt=0 with no frame_tick for the aborted frame.

Configuration
REQ-015 SHALL: macro VGA_BLINK_EN defined -> a frame counter counts frame_tick pulses and blink toggles every BLINK_FRAMES frames; the frame counter is reset by clr.
REQ-016 SHALL: VGA_BLINK_EN undefined -> no frame counter is built and blink is tied to 0; all other behaviour is identical.

Structure
REQ-017 SHALL: package vga_timing_pkg holds the timing constants, H_TOTAL, V_TOTAL and the sync start/end values derived from them.
REQ-018 SHALL: one sub-module, vga_axis_counter (mod-N counter with enable and wrap output), instantiated twice, once for horizontal and once for vertical.

Verification
REQ-019 SHALL: assert clr mid-run -> all outputs at reset values within the same cycle; after release, Pixel_X=0 and Pixel_Y=0, and vga_on=1 within 2 clk.
REQ-020 SHALL: run 1600 clk after reset -> v_cnt=1; Pixel_X sequence is 0..799, each value held 2 clk.
REQ-021 SHALL: per line, hsync low for exactly 192 clk, with the falling edge when Pixel_X first equals 656; per frame, vsync low for 3200 clk.
REQ-022 SHALL: per frame, 614400 clk with vga_on=1 (307200 pixels); Pixel_X never exceeds 639 while vga_on=1.
REQ-023 SHALL: frame_tick pulses are exactly 840000 clk apart, each 1 clk wide.
REQ-024 SHALL: with VGA_BLINK_EN, blink toggles after 32 frame_tick pulses; without VGA_BLINK_EN, blink stays 0 for 64 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and window helper shared by the VGA sync generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int ROW_W = 9;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int BLINK_FRAMES_DEF = 32;

  localparam int H_TOTAL      = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_DISPLAY_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISPLAY_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Inclusive range test of a counter value against integer bounds.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N up counter with enable; o_wrap flags the enabled step that returns the count to zero.
module vga_axis_counter
#(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);
  assign o_cnt  = r_cnt;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       r_cnt <= '0;
    else if (i_en) r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: half-rate pixel tick, h/v counters, registered sync/visible/pixel outputs.
// Optional cursor blink phase is built only when VGA_BLINK_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY    = H_DISPLAY_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_DISPLAY    = V_DISPLAY_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       clr,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_on,
  output logic [9:0] Pixel_X,
  output logic [8:0] Pixel_Y,
  output logic       frame_tick,
  output logic       blink
);

  localparam int H_LEN    = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_LEN    = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_DISPLAY + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_DISPLAY + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic             r_tick;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_vga_on;
  logic [9:0]       r_pixel_x;
  logic [8:0]       r_pixel_y;
  logic             r_frame_tick;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_tick <= 1'b0;
    else     r_tick <= ~r_tick;
  end

  vga_axis_counter #(.N(H_LEN), .W(CNT_W)) u_h_counter (
    .clk    (clk),
    .clr    (clr),
    .i_en   (r_tick),
    .o_cnt  (w_h_cnt),
    .o_wrap (w_h_wrap)
  );

  // The horizontal wrap already carries the tick, so it alone steps the line count.
  vga_axis_counter #(.N(V_LEN), .W(CNT_W)) u_v_counter (
    .clk    (clk),
    .clr    (clr),
    .i_en   (w_h_wrap),
    .o_cnt  (w_v_cnt),
    .o_wrap (w_v_wrap)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_vga_on     <= 1'b0;
      r_pixel_x    <= '0;
      r_pixel_y    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hsync      <= ~in_window(w_h_cnt, HS_FIRST, HS_LAST);
      r_vsync      <= ~in_window(w_v_cnt, VS_FIRST, VS_LAST);
      r_vga_on     <= in_window(w_h_cnt, 0, H_DISPLAY - 1) && in_window(w_v_cnt, 0, V_DISPLAY - 1);
      r_pixel_x    <= w_h_cnt;
      r_pixel_y    <= w_v_cnt[ROW_W-1:0];
      r_frame_tick <= w_v_wrap;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign vga_on     = r_vga_on;
  assign Pixel_X    = r_pixel_x;
  assign Pixel_Y    = r_pixel_y;
  assign frame_tick = r_frame_tick;

`ifdef VGA_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] r_frame_cnt;
  logic               r_blink;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_frame_tick) begin
      if (r_frame_cnt == BLINK_LAST) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + BLINK_W'(1);
      end
    end
  end

  assign blink = r_blink;
`else
  // Held low; BLINK_FRAMES is still referenced so both builds accept one parameter set.
  assign blink = 1'b0 && (BLINK_FRAMES != 0);
`endif

endmodule
